// File: rtl/mips_pkg.sv
// Shared SoC definitions: factorial accelerator register offsets, FSM states and limits.
package mips_pkg;

    localparam logic [1:0] FACT_N      = 2'd0;
    localparam logic [1:0] FACT_GO     = 2'd1;
    localparam logic [1:0] FACT_STATUS = 2'd2;
    localparam logic [1:0] FACT_RESULT = 2'd3;

    // 13! is the first factorial that overflows 32 bits
    localparam int FACT_N_MAX = 12;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fact_state_t;

endpackage

// File: rtl/fact_fsm.sv
// Factorial sequencer: owns state, down-counter and sticky done/err; drives datapath controls.
module fact_fsm
    import mips_pkg::*;
#(
    parameter int N_MAX = FACT_N_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] n,
    output logic [3:0] cnt,
    output logic       load,
    output logic       step,
    output logic       finish,
    output logic       range_err,
    output logic       done,
    output logic       err
);

    fact_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        range_err = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (32'(n) > N_MAX) begin
                        range_err = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // GO is only honoured in IDLE, so a GO while busy leaves done/err alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (load) begin
                cnt  <= n;
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (range_err) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if (step)   cnt  <= cnt - 4'd1;
            if (finish) done <= 1'b1;
        end
    end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: register file, acc/RESULT datapath and bus read mux.
module fact_accel
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_MAX  = FACT_N_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              done,
    output logic              err
);

    logic [3:0]        n_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] result;
    logic              load, step, finish, range_err;
    logic              go;
    logic              unused_wd;

    assign go        = we && (a == FACT_GO) && wd[0];
    assign unused_wd = ^wd[DATA_W-1:4];

    fact_fsm #(.N_MAX(N_MAX)) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .n        (n_q),
        .cnt      (cnt),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .range_err(range_err),
        .done     (done),
        .err      (err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            if (we && (a == FACT_N)) n_q <= wd[3:0];
            if (load)      acc    <= DATA_W'(1);
            if (step)      acc    <= acc * DATA_W'(cnt);
            if (finish)    result <= acc;
            if (range_err) result <= '0;
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            FACT_N:      rd = DATA_W'(n_q);
            FACT_GO:     rd = '0;
            FACT_STATUS: rd = DATA_W'({err, done});
            FACT_RESULT: rd = result;
            default:     rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// Directed bench for fact_accel: vector table of n -> n!, latency and status, plus busy/reset sequences.
module tb_fact_accel;

    localparam int DATA_W = 32;
    localparam int TMO    = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we  = 1'b0;
    logic [1:0]        a   = 2'd0;
    logic [DATA_W-1:0] wd  = '0;
    logic [DATA_W-1:0] rd;
    logic              done, err;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    fact_accel #(.DATA_W(DATA_W), .N_MAX(12)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd),
        .done(done),
        .err (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] res;
        int          lat;
        logic [31:0] status;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1; a = addr; wd = data;
        @(posedge clk);
        #1;
        we = 1'b0; wd = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        a = addr;
        #1;
        data = rd;
    endtask

    // Issue GO and return edges from the GO edge until done is seen (TMO on timeout)
    task automatic go_and_wait(output int lat);
        int unsigned k;
        bus_write(2'd1, 32'h1);
        k = cyc;
        while (!done && (cyc - k) < TMO) begin
            @(posedge clk);
            #1;
        end
        lat = int'(cyc - k);
    endtask

    vec_t        vecs[9];
    logic [31:0] r;
    int          lat;
    int unsigned k;

    initial begin
        vecs[0] = '{4'd5,  32'h0000_0078, 5,  32'h1};
        vecs[1] = '{4'd0,  32'h0000_0001, 1,  32'h1};
        vecs[2] = '{4'd1,  32'h0000_0001, 1,  32'h1};
        vecs[3] = '{4'd12, 32'h1C8C_FC00, 12, 32'h1};
        vecs[4] = '{4'd13, 32'h0000_0000, 0,  32'h3};
        vecs[5] = '{4'd3,  32'h0000_0006, 3,  32'h1};
        vecs[6] = '{4'd7,  32'h0000_13B0, 7,  32'h1};
        vecs[7] = '{4'd15, 32'h0000_0000, 0,  32'h3};
        vecs[8] = '{4'd2,  32'h0000_0002, 2,  32'h1};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), r);
            chk($sformatf("reset_rd_%0d", i), r, 32'h0);
        end
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_err",  {31'b0, err},  32'h0);

        // N keeps only bits [3:0]; read-only offsets ignore writes
        bus_write(2'd0, 32'hFFFF_FFF5);
        bus_read(2'd0, r);
        chk("n_mask", r, 32'h5);
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_write(2'd2, 32'h3);
        bus_read(2'd3, r);
        chk("result_ro", r, 32'h0);
        bus_read(2'd2, r);
        chk("status_ro", r, 32'h0);

        for (int i = 0; i < 9; i++) begin
            bus_write(2'd0, {28'b0, vecs[i].n});
            go_and_wait(lat);
            chk($sformatf("lat_n%0d", vecs[i].n), 32'(lat), 32'(vecs[i].lat));
            bus_read(2'd3, r);
            chk($sformatf("result_n%0d", vecs[i].n), r, vecs[i].res);
            bus_read(2'd2, r);
            chk($sformatf("status_n%0d", vecs[i].n), r, vecs[i].status);
            chk($sformatf("err_port_n%0d", vecs[i].n), {31'b0, err}, {31'b0, vecs[i].status[1]});
            bus_read(2'd1, r);
            chk($sformatf("go_rd_n%0d", vecs[i].n), r, 32'h0);
        end

        // GO and N writes while busy are ignored by the running computation
        bus_write(2'd0, 32'd6);
        bus_write(2'd1, 32'h1);
        k = cyc;
        bus_write(2'd0, 32'd2);
        bus_write(2'd1, 32'h1);
        bus_read(2'd3, r);
        chk("busy_result_held", r, 32'h2);
        chk("busy_done_low", {31'b0, done}, 32'h0);
        while (!done && (cyc - k) < TMO) begin
            @(posedge clk);
            #1;
        end
        chk("busy_lat", cyc - k, 32'd6);
        bus_read(2'd3, r);
        chk("busy_result", r, 32'h2D0);
        bus_read(2'd0, r);
        chk("busy_n_rd", r, 32'h2);

        // Reset mid-run aborts immediately
        bus_write(2'd0, 32'd10);
        bus_write(2'd1, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        a = 2'd3;
        #1;
        chk("abort_result", rd, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_read(2'd0, r);
        chk("abort_n", r, 32'h0);
        bus_write(2'd0, 32'd4);
        go_and_wait(lat);
        chk("after_abort_lat", 32'(lat), 32'd4);
        bus_read(2'd3, r);
        chk("after_abort_result", r, 32'h18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
